// File: rtl/array_max_scanner.sv
// Signed max-search engine that borrows the data memory port.
// Scans N big-endian words, then writes the max and its index.
module array_max_scanner #(
  parameter logic [31:0] MAX_ADDR = 32'd2000,
  parameter logic [31:0] IDX_ADDR = 32'd2004,
  parameter int          LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result_max,
  output logic [31:0]      result_index,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WR_MAX,
    WR_IDX,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [31:0]      base_q;
  logic [31:0]      max_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] i_q;
  logic [LEN_W-1:0] idx_q;
  logic [31:0]      elem_addr;
  logic             last;
  logic             take;

  assign elem_addr = base_q + (32'(i_q) << 2);
  assign last      = (i_q == len_q - 1'b1);
  // Strict compare keeps the first occurrence on a tie.
  assign take      = (i_q == '0) ||
                     ($signed(mem_read_data) > $signed(max_q));

  always_comb begin
    state_n        = state;
    busy           = (state != IDLE);
    done           = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (length == '0) ? DONE : SETUP;
      end
      SETUP: begin
        mem_address = elem_addr;
        state_n     = READ;
      end
      READ: begin
        mem_address = elem_addr;
        mem_read    = 1'b1;
        state_n     = last ? WR_MAX : SETUP;
      end
      WR_MAX: begin
        mem_address    = MAX_ADDR;
        mem_write_data = max_q;
        mem_write      = 1'b1;
        state_n        = WR_IDX;
      end
      WR_IDX: begin
        mem_address    = IDX_ADDR;
        mem_write_data = 32'(idx_q);
        mem_write      = 1'b1;
        state_n        = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      i_q          <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      result_max   <= '0;
      result_index <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        len_q  <= length;
        i_q    <= '0;
        if (length == '0) begin
          result_max   <= '0;
          result_index <= '0;
        end
      end
      if (state == READ) begin
        if (take) begin
          max_q <= mem_read_data;
          idx_q <= i_q;
        end
        if (!last)
          i_q <= i_q + 1'b1;
      end
      if (state == WR_IDX) begin
        result_max   <= max_q;
        result_index <= 32'(idx_q);
      end
    end
  end

endmodule

// File: tb/tb_array_max_scanner.sv
// Directed bench for array_max_scanner with a byte-wide
// big-endian memory model and a result scoreboard.
module tb_array_max_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [31:0] result_max;
  logic [31:0] result_index;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_rd = 1'b0;

  logic [7:0] mem [0:4095];

  typedef struct {
    logic [31:0] mx;
    logic [31:0] ix;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  array_max_scanner dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .result_max(result_max),
    .result_index(result_index),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  // 4 KiB model; addresses alias modulo 4096, so 32-bit wrap maps cleanly.
  logic [11:0] ra;
  assign ra = mem_address[11:0];
  assign mem_read_data = {mem[ra], mem[ra + 12'd1],
                          mem[ra + 12'd2], mem[ra + 12'd3]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ra]         <= mem_write_data[31:24];
      mem[ra + 12'd1] <= mem_write_data[23:16];
      mem[ra + 12'd2] <= mem_write_data[15:8];
      mem[ra + 12'd3] <= mem_write_data[7:0];
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read)
      rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      total += 3;
      assert (!(mem_read && prev_rd)) else begin
        bad++;
        $error("FAIL rd_back2back obs=1 exp=0 t=%0t", $time);
      end
      assert (!(mem_read && mem_write)) else begin
        bad++;
        $error("FAIL rd_and_wr obs=1 exp=0 t=%0t", $time);
      end
      assert (busy || {mem_address, mem_write_data,
                       mem_read, mem_write} == '0) else begin
        bad++;
        $error("FAIL idle_mem obs=%h exp=0 t=%0t",
               {mem_address, mem_write_data}, $time);
      end
    end
    prev_rd = mem_read;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    logic [11:0] b;
    b = a[11:0];
    mem[b]         = w[31:24];
    mem[b + 12'd1] = w[23:16];
    mem[b + 12'd2] = w[15:8];
    mem[b + 12'd3] = w[7:0];
  endtask

  function automatic logic [31:0] get_word(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {mem[b], mem[b + 12'd1], mem[b + 12'd2], mem[b + 12'd3]};
  endfunction

  // Start a scan, push expectations, then pop and compare on done.
  task automatic run(input string tag, input logic [31:0] base,
                     input logic [15:0] n, input logic [31:0] mx,
                     input logic [31:0] ix);
    exp_t e;
    exp_t g;
    int   lat;
    e.mx  = mx;
    e.ix  = ix;
    e.lat = (n == 0) ? 1 : 2 * int'(n) + 3;
    sb.push_back(e);
    @(posedge clk); #1;
    base_addr = base;
    length    = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    g = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(g.lat));
    if (lat != 0) begin
      chk({tag, "_max"}, result_max, g.mx);
      chk({tag, "_idx"}, result_index, g.ix);
    end
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_held_max"}, result_max, g.mx);
  endtask

  int          w0;
  int          r0;
  logic [31:0] m0;
  logic [31:0] m1;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {31'd0, |{busy, done, result_max, result_index,
                               mem_address, mem_write_data,
                               mem_read, mem_write}}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Test 1: tie on 17, first occurrence wins.
    put_word(32'd1000, 32'd5);
    put_word(32'd1004, -32'sd3);
    put_word(32'd1008, 32'd17);
    put_word(32'd1012, 32'd17);
    put_word(32'd1016, 32'd2);
    run("t1", 32'd1000, 16'd5, 32'h11, 32'd2);
    chk("t1_mem_max", get_word(32'd2000), 32'h0000_0011);
    chk("t1_mem_idx", get_word(32'd2004), 32'h0000_0002);

    // Test 2: all negative, signed compare.
    put_word(32'd1200, -32'sd8);
    put_word(32'd1204, -32'sd2);
    put_word(32'd1208, -32'sd5);
    run("t2", 32'd1200, 16'd3, 32'hFFFF_FFFE, 32'd1);
    chk("t2_mem_max", get_word(32'd2000), 32'hFFFF_FFFE);
    chk("t2_mem_idx", get_word(32'd2004), 32'd1);

    // Test 3: single element, most positive value.
    put_word(32'd1000, 32'h7FFF_FFFF);
    run("t3", 32'd1000, 16'd1, 32'h7FFF_FFFF, 32'd0);
    chk("t3_mem_max", get_word(32'd2000), 32'h7FFF_FFFF);

    // Address wrap: element 1 lives at address 0.
    put_word(32'hFFFF_FFFC, 32'd3);
    put_word(32'h0000_0000, 32'd9);
    run("wrap", 32'hFFFF_FFFC, 16'd2, 32'd9, 32'd1);
    chk("wrap_mem_idx", get_word(32'd2004), 32'd1);

    // Test 4: N=0 clears results, no memory traffic.
    w0 = wr_cnt;
    r0 = rd_cnt;
    m0 = get_word(32'd2000);
    run("t4", 32'd1000, 16'd0, 32'd0, 32'd0);
    chk("t4_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("t4_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("t4_mem_max", get_word(32'd2000), m0);

    // Test 5: start ignored while busy, reset during READ of element 2.
    put_word(32'd1000, 32'd5);
    w0 = wr_cnt;
    m0 = get_word(32'd2000);
    m1 = get_word(32'd2004);
    @(posedge clk); #1;
    base_addr = 32'd1000;
    length = 16'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    base_addr = 32'd1600;
    length = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_busy_c5", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rd_c6", {31'd0, mem_read}, 32'd1);
    chk("t5_addr_c6", mem_address, 32'd1008);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy_c7", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("t5_mem_max", get_word(32'd2000), m0);
    chk("t5_mem_idx", get_word(32'd2004), m1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
